// File: rtl/movem_register_sequencer_pkg.sv
// Shared types and constants for the MOVEM register sequencer.
// Used by movem_register_sequencer and movem_mask_encoder.
package movem_register_sequencer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 16;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned RAM_AW = 3;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic [BE_W-1:0]   BE_LONG   = 4'b1111;
    localparam logic [BE_W-1:0]   BE_WORD   = 4'b0011;
    localparam logic [DATA_W-1:0] SIZE_WORD = 32'd2;
    localparam logic [DATA_W-1:0] SIZE_LONG = 32'd4;

    typedef struct packed {
        logic [MASK_W-1:0] mask;
        logic              to_memory;
        logic              long_size;
        logic              predecrement;
    } ctrl_t;

    // Predecrement mode walks the mask reversed: bit i names register 15-i.
    function automatic logic [IDX_W-1:0] reg_of(input logic [IDX_W-1:0] idx,
                                                 input logic predec);
        return predec ? IDX_W'(4'd15 - idx) : idx;
    endfunction

endpackage

// File: rtl/movem_mask_encoder.sv
// Lowest-set-bit priority encoder over the 16-bit remaining register mask.
module movem_mask_encoder
    import movem_register_sequencer_pkg::*;
(
    input  logic [MASK_W-1:0] mask,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    // Scan downward so the lowest set bit is the last one assigned.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/movem_register_sequencer.sv
// MOVEM multi-register transfer sequencer between the D/A register RAMs and memory.
// Optional macro MOVEM_SEQ_ADDRESS_EN adds memory address generation ports.
module movem_register_sequencer
    import movem_register_sequencer_pkg::*;
#(
    parameter bit SIGN_EXTEND_WORD = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [MASK_W-1:0] mask,
    input  logic              to_memory,
    input  logic              long_size,
    input  logic              predecrement,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [RAM_AW-1:0] d_address,
    output logic [BE_W-1:0]   d_byte_enable,
    output logic              d_write_enable,
    output logic [DATA_W-1:0] d_data_input,
    input  logic [DATA_W-1:0] d_data_output,
    output logic [RAM_AW-1:0] a_address,
    output logic [BE_W-1:0]   a_byte_enable,
    output logic              a_write_enable,
    output logic [DATA_W-1:0] a_data_input,
    input  logic [DATA_W-1:0] a_data_output
`ifdef MOVEM_SEQ_ADDRESS_EN
    ,
    input  logic [DATA_W-1:0] base_address,
    output logic [DATA_W-1:0] mem_address,
    output logic [DATA_W-1:0] final_address
`endif
);

    state_e            state_q, state_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [IDX_W-1:0]  idx;
    logic              any;
    logic [IDX_W-1:0]  reg_sel;
    logic              xfer_live;
    logic              store_hs;
    logic              load_hs;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] wr_data;
    logic [BE_W-1:0]   wr_be;
`ifdef MOVEM_SEQ_ADDRESS_EN
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] final_q, final_d;
    logic [DATA_W-1:0] size_cur;
    logic [DATA_W-1:0] size_new;
`endif

    movem_mask_encoder u_enc (
        .mask (ctrl_q.mask),
        .idx  (idx),
        .any  (any)
    );

    assign reg_sel   = reg_of(idx, ctrl_q.predecrement);
    assign xfer_live = (state_q == ST_ACTIVE) && any;
    assign store_hs  = xfer_live && ctrl_q.to_memory && out_ready;
    assign load_hs   = xfer_live && !ctrl_q.to_memory && in_valid;
    assign rd_data   = reg_sel[3] ? a_data_output : d_data_output;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
`ifdef MOVEM_SEQ_ADDRESS_EN
            mem_addr_q <= '0;
            final_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
`ifdef MOVEM_SEQ_ADDRESS_EN
            mem_addr_q <= mem_addr_d;
            final_q    <= final_d;
`endif
        end
    end

    always_comb begin
        state_d        = state_q;
        ctrl_d         = ctrl_q;
        busy           = 1'b0;
        done           = 1'b0;
        out_valid      = 1'b0;
        out_data       = '0;
        in_ready       = 1'b0;
        d_address      = '0;
        d_byte_enable  = '0;
        d_write_enable = 1'b0;
        d_data_input   = '0;
        a_address      = '0;
        a_byte_enable  = '0;
        a_write_enable = 1'b0;
        a_data_input   = '0;
        wr_be          = (ctrl_q.long_size || SIGN_EXTEND_WORD) ? BE_LONG : BE_WORD;
        wr_data        = in_data;
        if (!ctrl_q.long_size && SIGN_EXTEND_WORD) begin
            wr_data = {{16{in_data[15]}}, in_data[15:0]};
        end
`ifdef MOVEM_SEQ_ADDRESS_EN
        mem_addr_d = mem_addr_q;
        final_d    = final_q;
        size_cur   = ctrl_q.long_size ? SIZE_LONG : SIZE_WORD;
        size_new   = long_size ? SIZE_LONG : SIZE_WORD;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ctrl_d  = '{mask: mask, to_memory: to_memory,
                                long_size: long_size, predecrement: predecrement};
                    state_d = ST_ACTIVE;
`ifdef MOVEM_SEQ_ADDRESS_EN
                    mem_addr_d = predecrement ? (base_address - size_new) : base_address;
                    final_d    = base_address;
`endif
                end
            end
            ST_ACTIVE: begin
                busy = 1'b1;
                if (!any) begin
                    state_d = ST_DONE;
                end else if (store_hs || load_hs) begin
                    ctrl_d.mask = ctrl_q.mask & ~(MASK_W'(1) << idx);
`ifdef MOVEM_SEQ_ADDRESS_EN
                    // Predecrement keeps the last used address for the An writeback.
                    final_d    = ctrl_q.predecrement ? mem_addr_q : (mem_addr_q + size_cur);
                    mem_addr_d = ctrl_q.predecrement ? (mem_addr_q - size_cur)
                                                     : (mem_addr_q + size_cur);
`endif
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (xfer_live) begin
            out_valid = ctrl_q.to_memory;
            in_ready  = !ctrl_q.to_memory;
            if (ctrl_q.to_memory) begin
                out_data = ctrl_q.long_size ? rd_data : {16'h0000, rd_data[15:0]};
            end
            if (reg_sel[3]) begin
                a_address      = reg_sel[2:0];
                a_byte_enable  = wr_be;
                a_write_enable = load_hs;
                a_data_input   = wr_data;
            end else begin
                d_address      = reg_sel[2:0];
                d_byte_enable  = wr_be;
                d_write_enable = load_hs;
                d_data_input   = wr_data;
            end
        end
    end

`ifdef MOVEM_SEQ_ADDRESS_EN
    assign mem_address   = mem_addr_q;
    assign final_address = final_q;
`endif

endmodule
